// File: rtl/dsp_post_adder_p_stage_if.sv
// Operand/result bundle between the X/Z/CIN muxes, the post-adder and the P consumers.
// Pure wiring, no latency.
// No backpressure: clock enables (ce_p, ce_carry) are the only stall controls.
interface dsp_post_adder_p_stage_if #(
  parameter int WIDTH = 48
);
  logic [WIDTH-1:0] x_in;
  logic [WIDTH-1:0] z_in;
  logic             cin;
  logic             sub;
  logic             ce_p;
  logic             ce_carry;
  logic             in_valid;
  logic             clr_ovf;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] pcout;
  logic             carryout;
  logic             carryoutf;
  logic             out_valid;
  logic             ovf_sticky;
`ifdef DSP_PATTERN_DETECT_EN
  logic             pattern_detect;
`endif

  // Upstream side: drives operands/controls, observes the P stage
  modport master (
    output x_in, z_in, cin, sub, ce_p, ce_carry, in_valid, clr_ovf,
`ifdef DSP_PATTERN_DETECT_EN
    input  pattern_detect,
`endif
    input  p, pcout, carryout, carryoutf, out_valid, ovf_sticky
  );

  // P stage side
  modport slave (
    input  x_in, z_in, cin, sub, ce_p, ce_carry, in_valid, clr_ovf,
`ifdef DSP_PATTERN_DETECT_EN
    output pattern_detect,
`endif
    output p, pcout, carryout, carryoutf, out_valid, ovf_sticky
  );
endinterface

// File: rtl/dsp_post_adder_p_stage.sv
// DSP48A1 post-adder/subtractor + P register: P = Z +/- (X + CIN), carryout, valid tag, sticky overflow.
// Latency: 1 cycle with PREG=1 (carryout 1 cycle with CARRYOUTREG=1), 0 otherwise; ovf_sticky always registered.
// No backpressure: ce_p holds P/valid/ovf-set, ce_carry holds carryout. Optional: DSP_PATTERN_DETECT_EN.
module dsp_post_adder_p_stage #(
  parameter int PREG        = 1,
  parameter int CARRYOUTREG = 1,
  parameter int WIDTH       = 48
`ifdef DSP_PATTERN_DETECT_EN
  ,
  parameter logic [WIDTH-1:0] PATTERN = '0,
  parameter logic [WIDTH-1:0] MASK    = '0
`endif
) (
  input logic                     clk,
  input logic                     rst_n,
  dsp_post_adder_p_stage_if.slave bus
);

  logic [WIDTH:0]   r;
  logic [WIDTH-1:0] p_next;
  logic             carry_next;
  logic             ovf_now;

  logic [WIDTH-1:0] p_q, p_d;
  logic             valid_q, valid_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;

  // Post-adder: one 49-bit add/subtract; bit WIDTH is carry (add) or borrow (sub)
  always_comb begin
    r = '0;
    if (bus.sub) begin
      r = {1'b0, bus.z_in} - {1'b0, bus.x_in} - {{WIDTH{1'b0}}, bus.cin};
    end else begin
      r = {1'b0, bus.z_in} + {1'b0, bus.x_in} + {{WIDTH{1'b0}}, bus.cin};
    end
  end

  assign p_next     = r[WIDTH-1:0];
  assign carry_next = r[WIDTH];

  // Signed overflow judged from operand and result sign bits
  always_comb begin
    ovf_now = 1'b0;
    if (bus.sub) begin
      ovf_now = (bus.z_in[WIDTH-1] != bus.x_in[WIDTH-1]) && (r[WIDTH-1] != bus.z_in[WIDTH-1]);
    end else begin
      ovf_now = (bus.z_in[WIDTH-1] == bus.x_in[WIDTH-1]) && (r[WIDTH-1] != bus.z_in[WIDTH-1]);
    end
  end

  // Next-state for the P, valid, carry and sticky-overflow registers
  always_comb begin
    p_d     = p_q;
    valid_d = valid_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    if (bus.ce_p) begin
      p_d     = p_next;
      valid_d = bus.in_valid;
    end
    if (bus.ce_carry) begin
      carry_d = carry_next;
    end
    // A set in the same cycle as a clear must win so no overflow is lost
    if (bus.ce_p && bus.in_valid && ovf_now) begin
      ovf_d = 1'b1;
    end else if (bus.clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  // State registers; reset dominates every enable and the clear
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p_q     <= '0;
      valid_q <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      p_q     <= p_d;
      valid_q <= valid_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.p          = (PREG != 0) ? p_q : p_next;
  assign bus.pcout      = bus.p;
  assign bus.out_valid  = (PREG != 0) ? valid_q : bus.in_valid;
  assign bus.carryout   = (CARRYOUTREG != 0) ? carry_q : carry_next;
  assign bus.carryoutf  = bus.carryout;
  assign bus.ovf_sticky = ovf_q;

`ifdef DSP_PATTERN_DETECT_EN
  logic pd_next;
  logic pd_q, pd_d;

  assign pd_next = (((p_next ^ PATTERN) & ~MASK) == '0);

  // Pattern flag tracks P: loads only under ce_p
  always_comb begin
    pd_d = pd_q;
    if (bus.ce_p) begin
      pd_d = pd_next;
    end
  end

  // Pattern flag register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pd_q <= 1'b0;
    end else begin
      pd_q <= pd_d;
    end
  end

  assign bus.pattern_detect = (PREG != 0) ? pd_q : pd_next;
`endif

endmodule
